// File: rtl/div_inner.sv
// div_inner: bit-serial signed restoring divider.
// Operands are converted to magnitudes at accept and one quotient bit is
// produced per cycle, MSB first. The signs are applied to the quotient and
// remainder in the first DONE cycle, and the result is then held for the
// downstream valid/ready handshake.
module div_inner #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_dbz,
  output logic             o_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t state;
  state_t state_next;

  // Operand magnitudes, signs and the original dividend (returned on divide-by-zero)
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_orig;
  logic             sign_a;
  logic             sign_b;

  // Iteration state: partial remainder, quotient bits and bit index
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [DEPTH-1:0] cnt;

  // Special-case flags captured at accept
  logic             dbz_q;
  logic             ovf_q;

  // Combinational helpers
  logic             accept;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_r;

  // Input acceptance and operand magnitudes (|min_int| still fits unsigned)
  always_comb begin
    accept  = (state == IDLE) && i_valid && !clr;
    dvd_abs = i_dividend[WIDTH-1] ? (~i_dividend + ONE) : i_dividend;
    dvs_abs = i_divisor[WIDTH-1]  ? (~i_divisor  + ONE) : i_divisor;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // After a subtraction the result is below the divisor, so it fits in WIDTH bits.
  always_comb begin
    rem_shift = {rem, dvd_mag[cnt]};
    rem_ge    = rem_shift >= {1'b0, dvs_mag};
    rem_sub   = rem_shift[WIDTH-1:0] - dvs_mag;
  end

  // Sign correction and special-case overrides for the final result
  always_comb begin
    res_q = (sign_a ^ sign_b) ? (~quo + ONE) : quo;
    res_r = sign_a ? (~rem + ONE) : rem;
    if (dbz_q) begin
      res_q = ALL_ONES;
      res_r = dvd_orig;
    end else if (ovf_q) begin
      res_q = MIN_INT;
      res_r = '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; clr returns to IDLE from any state
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (i_valid) state_next = BUSY;
        BUSY: if (cnt == '0) state_next = DONE;
        DONE: if (o_valid && o_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    i_ready = (state == IDLE);
  end

  // Operand capture and one quotient bit per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_mag  <= '0;
      dvs_mag  <= '0;
      dvd_orig <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (clr) begin
      dvd_mag  <= '0;
      dvs_mag  <= '0;
      dvd_orig <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      dvd_mag  <= dvd_abs;
      dvs_mag  <= dvs_abs;
      dvd_orig <= i_dividend;
      sign_a   <= i_dividend[WIDTH-1];
      sign_b   <= i_divisor[WIDTH-1];
      rem      <= '0;
      quo      <= '0;
      cnt      <= DEPTH'(WIDTH - 1);
      dbz_q    <= (i_divisor == '0);
      ovf_q    <= (i_dividend == MIN_INT) && (i_divisor == ALL_ONES);
    end else if (state == BUSY) begin
      rem      <= rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
      quo[cnt] <= rem_ge;
      if (cnt != '0) begin
        cnt <= cnt - DEPTH'(1);
      end
    end
  end

  // Result registers: loaded in the first DONE cycle, held until o_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid     <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_dbz       <= 1'b0;
      o_ovf       <= 1'b0;
    end else if (clr) begin
      o_valid     <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_dbz       <= 1'b0;
      o_ovf       <= 1'b0;
    end else if (accept) begin
      o_valid <= 1'b0;
      o_dbz   <= 1'b0;
      o_ovf   <= 1'b0;
    end else if ((state == DONE) && !o_valid) begin
      o_valid     <= 1'b1;
      o_quotient  <= res_q;
      o_remainder <= res_r;
      o_dbz       <= dbz_q;
      o_ovf       <= ovf_q;
    end else if ((state == DONE) && o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
